// File: rtl/mem_stage.sv
// Memory-access stage: holds an EX result, waits for load data, aligns it
// and hands the instruction to WB; also feeds the ID forwarding/stall bus.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 74,
    parameter int MS_TO_WS_BUS_WD = 70,
    parameter int FWD_BUS_WD      = 39
) (
    input  logic                       clk,
    input  logic                       resetn,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [FWD_BUS_WD-1:0]      ms_fwd_bus
);

    logic                       ms_valid_q, ms_valid_d;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus_q, es_bus_d;
    logic                       buf_valid_q, buf_valid_d;
    logic [31:0]                buf_q, buf_d;

    logic        res_from_mem;
    logic [2:0]  ld_type;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    assign res_from_mem = es_bus_q[73];
    assign ld_type      = es_bus_q[72:70];
    assign gr_we        = es_bus_q[69];
    assign dest         = es_bus_q[68:64];
    assign alu_result   = es_bus_q[63:32];
    assign pc           = es_bus_q[31:0];

    logic ms_ready_go;
    logic ms_leave;

    assign ms_ready_go    = !res_from_mem || buf_valid_q || data_sram_data_ok;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign ms_leave       = ms_valid_q && ms_ready_go && ws_allowin;

    logic [31:0] ld_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_res;
    logic [31:0] final_result;

    assign ld_data = buf_valid_q ? buf_q : data_sram_rdata;

    always_comb begin
        byte_sel = ld_data[7:0];
        case (alu_result[1:0])
            2'd1:    byte_sel = ld_data[15:8];
            2'd2:    byte_sel = ld_data[23:16];
            2'd3:    byte_sel = ld_data[31:24];
            default: byte_sel = ld_data[7:0];
        endcase
    end

    // Halfword offset only looks at bit 1; misalignment is trapped in EX.
    assign half_sel = alu_result[1] ? ld_data[31:16] : ld_data[15:0];

    always_comb begin
        load_res = ld_data;
        case (ld_type)
            3'b001:  load_res = {{24{byte_sel[7]}}, byte_sel};
            3'b010:  load_res = {{16{half_sel[15]}}, half_sel};
            3'b011:  load_res = {24'd0, byte_sel};
            3'b100:  load_res = {16'd0, half_sel};
            default: load_res = ld_data;
        endcase
    end

    assign final_result = res_from_mem ? load_res : alu_result;

    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

    assign ms_fwd_bus = {ms_valid_q && gr_we,
                         ms_valid_q && res_from_mem && !ms_ready_go,
                         dest,
                         final_result};

    always_comb begin
        ms_valid_d  = ms_valid_q;
        es_bus_d    = es_bus_q;
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
        if (es_to_ms_valid && ms_allowin) begin
            es_bus_d = es_to_ms_bus;
        end
        // Keep returned data only when WB cannot take it this cycle.
        if (ms_leave) begin
            buf_valid_d = 1'b0;
        end else if (data_sram_data_ok && ms_valid_q && res_from_mem
                     && !buf_valid_q && !ws_allowin) begin
            buf_valid_d = 1'b1;
            buf_d       = data_sram_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q  <= 1'b0;
            es_bus_q    <= '0;
            buf_valid_q <= 1'b0;
            buf_q       <= 32'd0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            es_bus_q    <= es_bus_d;
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// single-instruction traffic checked against an arithmetic load model.
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [73:0] es_to_ms_bus;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [38:0] ms_fwd_bus;

    int total = 0;
    int bad   = 0;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_fwd_bus        (ms_fwd_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [73:0] mk_bus(input logic rfm, input logic [2:0] ld,
                                           input logic we, input logic [4:0] dst,
                                           input logic [31:0] alu, input logic [31:0] pc);
        return {rfm, ld, we, dst, alu, pc};
    endfunction

    // Byte/halfword picked by shifting, sign applied by subtracting 2^n.
    function automatic logic [31:0] model(input logic rfm, input logic [2:0] ld,
                                          input logic [31:0] alu, input logic [31:0] rd);
        int unsigned off;
        int unsigned v;
        off = alu % 4;
        if (!rfm) return alu;
        case (ld)
            3'd1: begin
                v = (rd >> (8 * off)) & 32'hFF;
                return (v >= 128) ? v - 256 : v;
            end
            3'd3: return (rd >> (8 * off)) & 32'hFF;
            3'd2: begin
                v = (rd >> (16 * (off / 2))) & 32'hFFFF;
                return (v >= 32768) ? v - 65536 : v;
            end
            3'd4: return (rd >> (16 * (off / 2))) & 32'hFFFF;
            default: return rd;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        ws_allowin        = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        tick();
        tick();
        total++;
        if (ms_to_ws_valid !== 1'b0 || ms_to_ws_bus !== 70'd0 ||
            ms_fwd_bus !== 39'd0 || ms_allowin !== 1'b1) begin
            bad++;
            $display("FAIL reset: valid=%b bus=%h fwd=%h allowin=%b want 0,0,0,1",
                     ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, ms_allowin);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(1'b0, 3'd0, 1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000);
        ws_allowin     = 1'b1;
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        total++;
        if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b1 ||
            ms_to_ws_bus !== {1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000}) begin
            bad++;
            $display("FAIL passthrough: valid=%b allowin=%b bus=%h want 1,1,%h",
                     ms_to_ws_valid, ms_allowin, ms_to_ws_bus,
                     {1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000});
        end
        tick();
    endtask

    task automatic test_load_align();
        logic [2:0]  lds  [6] = '{3'd1, 3'd3, 3'd4, 3'd2, 3'd2, 3'd0};
        logic [31:0] alus [6] = '{32'h3, 32'h3, 32'h2, 32'h2, 32'h0, 32'h1};
        logic [31:0] rds  [6] = '{32'h80AB_CD12, 32'h80AB_CD12, 32'h9876_5432,
                                  32'h9876_5432, 32'h9876_5432, 32'hCAFE_F00D};
        logic [31:0] exps [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_9876,
                                  32'hFFFF_9876, 32'h0000_5432, 32'hCAFE_F00D};
        for (int i = 0; i < 6; i++) begin
            es_to_ms_valid = 1'b1;
            es_to_ms_bus   = mk_bus(1'b1, lds[i], 1'b1, 5'd9, alus[i], 32'h1C00_0100);
            ws_allowin     = 1'b1;
            tick();
            es_to_ms_valid    = 1'b0;
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = rds[i];
            #1;
            total++;
            if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== exps[i]) begin
                bad++;
                $display("FAIL align%0d: valid=%b result=%h want 1,%h",
                         i, ms_to_ws_valid, ms_to_ws_bus[63:32], exps[i]);
            end
            tick();
            data_sram_data_ok = 1'b0;
        end
    endtask

    task automatic test_delayed();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(1'b1, 3'd0, 1'b1, 5'd7, 32'h100, 32'h1C00_0200);
        ws_allowin     = 1'b1;
        tick();
        es_to_ms_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_sram_rdata = $urandom;
            #1;
            total++;
            if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b0 || ms_fwd_bus[37] !== 1'b1) begin
                bad++;
                $display("FAIL delay_wait%0d: valid=%b allowin=%b stall=%b want 0,0,1",
                         i, ms_to_ws_valid, ms_allowin, ms_fwd_bus[37]);
            end
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hA5A5_1234;
        #1;
        total++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hA5A5_1234 ||
            ms_fwd_bus[37] !== 1'b0) begin
            bad++;
            $display("FAIL delay_done: valid=%b result=%h stall=%b want 1,a5a51234,0",
                     ms_to_ws_valid, ms_to_ws_bus[63:32], ms_fwd_bus[37]);
        end
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_backpressure();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(1'b1, 3'd0, 1'b1, 5'd3, 32'h40, 32'h1C00_0300);
        ws_allowin     = 1'b1;
        tick();
        es_to_ms_valid    = 1'b0;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        total++;
        if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0) begin
            bad++;
            $display("FAIL bp_pulse: valid=%b allowin=%b want 1,0",
                     ms_to_ws_valid, ms_allowin);
        end
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF) begin
                bad++;
                $display("FAIL bp_hold%0d: valid=%b result=%h want 1,deadbeef",
                         i, ms_to_ws_valid, ms_to_ws_bus[63:32]);
            end
            tick();
        end
        ws_allowin     = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(1'b1, 3'd0, 1'b1, 5'd4, 32'h44, 32'h1C00_0304);
        #1;
        total++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF ||
            ms_allowin !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: valid=%b result=%h allowin=%b want 1,deadbeef,1",
                     ms_to_ws_valid, ms_to_ws_bus[63:32], ms_allowin);
        end
        tick();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h1111_1111;
        #1;
        total++;
        if (ms_to_ws_valid !== 1'b0 || ms_fwd_bus[37] !== 1'b1) begin
            bad++;
            $display("FAIL bp_next_wait: valid=%b stall=%b want 0,1",
                     ms_to_ws_valid, ms_fwd_bus[37]);
        end
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5566_7788;
        #1;
        total++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h5566_7788) begin
            bad++;
            $display("FAIL bp_next_data: valid=%b result=%h want 1,55667788",
                     ms_to_ws_valid, ms_to_ws_bus[63:32]);
        end
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_async_reset();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(1'b1, 3'd0, 1'b1, 5'd8, 32'h80, 32'h1C00_0400);
        ws_allowin     = 1'b1;
        tick();
        es_to_ms_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        total++;
        if (ms_to_ws_valid !== 1'b0 || ms_to_ws_bus !== 70'd0 ||
            ms_fwd_bus !== 39'd0 || ms_allowin !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: valid=%b bus=%h fwd=%h allowin=%b want 0,0,0,1",
                     ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, ms_allowin);
        end
        tick();
        resetn = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h7777_7777;
        #1;
        total++;
        if (ms_to_ws_valid !== 1'b0) begin
            bad++;
            $display("FAIL stray_ok: valid=%b want 0", ms_to_ws_valid);
        end
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        total++;
        if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin
            bad++;
            $display("FAIL stray_after: valid=%b allowin=%b want 0,1",
                     ms_to_ws_valid, ms_allowin);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [73:0] sent [6];
        ws_allowin = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                sent[i] = mk_bus(1'b0, 3'd0, 1'(i % 2), 5'(i + 10), $urandom,
                                 32'h1C00_1000 + 32'(4 * i));
                es_to_ms_valid = 1'b1;
                es_to_ms_bus   = sent[i];
            end else begin
                es_to_ms_valid = 1'b0;
            end
            #1;
            if (i > 0) begin
                total++;
                if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b1 ||
                    ms_to_ws_bus !== {sent[i-1][69], sent[i-1][68:64],
                                      sent[i-1][63:32], sent[i-1][31:0]}) begin
                    bad++;
                    $display("FAIL b2b%0d: valid=%b allowin=%b bus=%h want 1,1,%h",
                             i, ms_to_ws_valid, ms_allowin, ms_to_ws_bus,
                             sent[i-1][69:0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic        rfm;
            logic [2:0]  ld;
            logic        we;
            logic [4:0]  dst;
            logic [31:0] alu, pc, rd, res;
            int          dly, cnt;
            logic        got, dok_sent, dok, ws, expv;
            rfm = 1'($urandom);
            ld  = 3'($urandom_range(0, 7));
            we  = 1'($urandom);
            dst = 5'($urandom);
            alu = $urandom;
            pc  = $urandom;
            rd  = $urandom;
            dly = $urandom_range(0, 3);
            res = model(rfm, ld, alu, rd);
            es_to_ms_valid = 1'b1;
            es_to_ms_bus   = mk_bus(rfm, ld, we, dst, alu, pc);
            ws_allowin     = 1'($urandom);
            #1;
            total++;
            if (ms_allowin !== 1'b1) begin
                bad++;
                $display("FAIL rnd%0d_accept: allowin=%b want 1", n, ms_allowin);
            end
            tick();
            es_to_ms_valid = 1'b0;
            got      = 1'b0;
            dok_sent = 1'b0;
            cnt      = 0;
            while (!got && cnt < 20) begin
                ws  = (cnt >= 10) ? 1'b1 : 1'($urandom);
                dok = rfm && !dok_sent && cnt >= dly;
                ws_allowin        = ws;
                data_sram_data_ok = dok;
                data_sram_rdata   = dok ? rd : $urandom;
                #1;
                expv = !rfm || dok_sent || dok;
                total++;
                if (ms_to_ws_valid !== expv || ms_fwd_bus[37] !== (rfm && !expv) ||
                    ms_fwd_bus[38] !== we || ms_fwd_bus[36:32] !== dst ||
                    (expv && ms_to_ws_bus !== {we, dst, res, pc})) begin
                    bad++;
                    $display("FAIL rnd%0d_c%0d: valid=%b fwd=%h bus=%h want %b,stall=%b,%h",
                             n, cnt, ms_to_ws_valid, ms_fwd_bus, ms_to_ws_bus,
                             expv, rfm && !expv, {we, dst, res, pc});
                end
                if (expv && ws) got = 1'b1;
                if (dok) dok_sent = 1'b1;
                tick();
                cnt++;
            end
            data_sram_data_ok = 1'b0;
            if (!got) begin
                total++;
                bad++;
                $display("FAIL rnd%0d_timeout: handoff=0 want 1", n);
            end
        end
        ws_allowin = 1'b1;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_align();
        test_delayed();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
